// File: rtl/lpc_io_host.sv
// lpc_io_host: LPC I/O-cycle initiator driving START/CTDIR/ADDR/TAR/SYNC/data phases.
// Optional SYNC timeout with ABORT sequence enabled by `define LPC_IO_HOST_TIMEOUT_EN.
module lpc_io_host #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);
    typedef enum logic [3:0] {IDLE, START, CTDIR, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR, ABORT} state_t;
    state_t state, nxt;
    logic [3:0] cnt, nxt_cnt, addr_nib, ad_n;
    logic wr, err_flag, fin, frame_n, oe_n, timeout;
    logic [15:0] addr;
    logic [7:0] wdata, rd_buf;
`ifdef LPC_IO_HOST_TIMEOUT_EN
    localparam int SW = $clog2(WAIT_LIMIT + 1);
    logic [SW-1:0] scnt;
    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) scnt <= '0;
        else scnt <= (state == SYNC) ? scnt + 1'b1 : '0;
    end
    assign timeout = scnt == SW'(WAIT_LIMIT - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req_valid) nxt = START;
            START:   nxt = CTDIR;
            CTDIR:   nxt = ADDR;
            ADDR:    if (cnt == 4'd3) nxt = wr ? WDATA : HTAR;
            WDATA:   if (cnt == 4'd1) nxt = HTAR;
            HTAR:    if (cnt == 4'd1) nxt = SYNC;
            // terminal SYNC codes take priority over the timeout
            SYNC:    if (lpc_ad_in == 4'b0000) nxt = wr ? PTAR : RDATA;
                     else if (lpc_ad_in == 4'b1010) nxt = PTAR;
                     else if (timeout) nxt = ABORT;
            RDATA:   if (cnt == 4'd1) nxt = PTAR;
            PTAR:    if (cnt == 4'd1) nxt = IDLE;
            ABORT:   if (cnt == 4'd3) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // outputs are decoded from the upcoming state so they land registered in that state
    always_comb begin
        nxt_cnt = (nxt != state) ? 4'd0 : cnt + 4'd1;
        fin = (state == PTAR && cnt == 4'd1) || (state == ABORT && cnt == 4'd3);
        frame_n = nxt == START || nxt == ABORT;
        oe_n = frame_n || nxt inside {CTDIR, ADDR, WDATA} || (nxt == HTAR && nxt_cnt == 4'd0);
        addr_nib = nxt_cnt[1:0] == 2'd0 ? addr[15:12] :
                   nxt_cnt[1:0] == 2'd1 ? addr[11:8] :
                   nxt_cnt[1:0] == 2'd2 ? addr[7:4] : addr[3:0];
        ad_n = nxt == START ? 4'b0000 :
               nxt == CTDIR ? {2'b00, wr, 1'b0} :
               nxt == ADDR  ? addr_nib :
               nxt == WDATA ? (nxt_cnt[0] ? wdata[7:4] : wdata[3:0]) : 4'hF;
    end
    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr         <= 1'b0;
            addr       <= 16'h0000;
            wdata      <= 8'h00;
            rd_buf     <= 8'h00;
            err_flag   <= 1'b0;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= 8'h00;
            lpc_frame  <= 1'b0;
            lpc_ad_oe  <= 1'b0;
            lpc_ad_out <= 4'hF;
        end else begin
            state      <= nxt;
            cnt        <= nxt_cnt;
            req_ready  <= nxt == IDLE;
            done       <= fin;
            lpc_frame  <= frame_n;
            lpc_ad_oe  <= oe_n;
            lpc_ad_out <= ad_n;
            if (state == IDLE && req_valid) begin
                wr       <= req_write;
                addr     <= req_addr;
                wdata    <= req_wdata;
                err_flag <= 1'b0;
            end
            if (state == SYNC && lpc_ad_in == 4'b1010) err_flag <= 1'b1;
            if (state == RDATA) rd_buf <= cnt[0] ? {lpc_ad_in, rd_buf[3:0]} : {rd_buf[7:4], lpc_ad_in};
            if (fin) begin
                err <= err_flag || state == ABORT;
                if (!wr && !err_flag && state == PTAR) rdata <= rd_buf;
            end
        end
    end
endmodule

// File: doc/lpc_io_host.md
# lpc_io_host

LPC I/O-cycle initiator: takes single-byte I/O read/write requests from a local request port and drives them onto the LPC bus as START, CYCTYPE/DIR, address, turn-around, SYNC and data phases. It is the bus-driving counterpart to the passive LPC decoder in the same design. It shares the decoder's `lpc_frame` polarity: high means frame asserted. A loopback bench can therefore wire the two together.

## Interface
- `WAIT_LIMIT`, default 16: maximum SYNC-phase cycles without a terminal SYNC before abort. Used only with `LPC_IO_HOST_TIMEOUT_EN`.
- `lpc_clock` in 1: single clock; all logic on its rising edge.
- `lpc_reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept.
- `req_write` in 1: 1 = I/O write, 0 = I/O read.
- `req_addr` in 16: I/O address.
- `req_wdata` in 8: write data.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 8: read data, valid with `done` on a successful read.
- `err` out 1: valid with `done`; 1 = error SYNC or abort.
- `lpc_frame` out 1: frame strobe, high during START and abort.
- `lpc_ad_out` out 4: driven nibble.
- `lpc_ad_oe` out 1: output enable for `lpc_ad_out`.
- `lpc_ad_in` in 4: sampled LAD.

## Operation
- **Handshake:** a request is accepted on an edge with `req_valid && req_ready`. The block latches `req_write`, `req_addr` and `req_wdata`. `req_ready` drops the next cycle.
- **FSM states:** IDLE, START, CTDIR, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR, ABORT.
- **IDLE:** `oe=0`, `ad_out=1111`, `frame=0`, `ready=1`.
- **START:** `frame=1`, `oe=1`, `ad=0000`.
- **CTDIR:** `ad={2'b00, write, 1'b0}`, giving 0000 for read and 0010 for write.
- **ADDR:** four cycles, addr[15:12], [11:8], [7:4], [3:0] in that order, MSB nibble first.
- **WDATA (write only):** two cycles, wdata[3:0] then wdata[7:4], low nibble first per LPC.
- **HTAR:** cycle 1 `oe=1`, `ad=1111`; cycle 2 `oe=0`.
- **SYNC:** `oe=0`; sample `lpc_ad_in` every cycle.
  - 0000: write goes to PTAR; read goes to RDATA.
  - 0101 or 0110: stay in SYNC (short/long wait).
  - 1010: error SYNC; go to PTAR and set the error flag. A read skips RDATA.
  - Any other value: treated as a wait.
- **RDATA:** two cycles; capture rdata[3:0] then rdata[7:4] from `lpc_ad_in`.
- **PTAR:** two cycles, `oe=0`; `lpc_ad_in` ignored. Then go to IDLE and pulse `done`.
- **Outputs:** `rdata` and `err` hold their value until the next `done`. `rdata` is unchanged on a write or on an error.
- **Internal counter:** one 4-bit phase counter, cleared on every state change. Address and data nibble selection is by counter value.
- **`req_valid` while busy:** ignored; no queuing.

## Timing
- **Reset values:** `req_ready=1`, `done=0`, `err=0`, `rdata=8'h00`, `lpc_frame=0`, `lpc_ad_oe=0`, `lpc_ad_out=4'hF`. FSM in IDLE, counter 0.
- **Output registration:** all outputs are registered. START is driven in the cycle after the accepting edge (cycle 1).
- **Zero-wait latency:** 13 bus cycles for both reads and writes.
  - Write: START 1, CTDIR 1, ADDR 4, WDATA 2, HTAR 2, SYNC 1, PTAR 2.
  - Read: START 1, CTDIR 1, ADDR 4, HTAR 2, SYNC 1, RDATA 2, PTAR 2.
- **Completion:** `done` is high in cycle 14, together with `req_ready=1`.
- **Back-to-back:** a new request may be accepted on the edge ending cycle 14, so START lands in cycle 15.
- **Wait SYNCs:** each adds exactly one cycle.
- **Reset mid-cycle:** `lpc_reset` asserted in any state returns to the reset values on the next edge. No abort sequence is driven. Nothing is pulsed: `done=0`, and any latched request is discarded.
- **Reset priority:** `lpc_reset` has priority over an accept on the same edge.

## Configuration
- **`LPC_IO_HOST_TIMEOUT_EN` defined:**
  - A SYNC counter counts cycles spent in SYNC.
  - If `WAIT_LIMIT` cycles pass without 0000 or 1010, the FSM enters ABORT.
  - ABORT: `frame=1`, `oe=1`, `ad=1111` for 4 cycles, then IDLE with `done=1`, `err=1`.
  - A terminal SYNC in the last allowed cycle wins over the timeout.
- **Not defined:** SYNC waits indefinitely; ABORT is unreachable; `WAIT_LIMIT` is unused.

## Test plan
- **Write, zero wait:** write `addr=16'h0080`, `wdata=8'hA5`, with `lpc_ad_in=0000` in SYNC.
  - LAD sequence: 0000(frame=1), 0010, 0, 0, 8, 0, 5, A, F, Z, then 0000 sampled.
  - `done` in cycle 14 with `err=0`.
- **Read, zero wait:** read `addr=16'h03F8`; the peripheral drives SYNC 0000, then 4'h7, then 4'h3.
  - CTDIR=0000; address nibbles 0, 3, F, 8.
  - `done` in cycle 14 with `rdata=8'h37`, `err=0`.
- **Wait states:** read with 3 cycles of 0110 before 0000.
  - `done` in cycle 17.
  - `oe=0` throughout SYNC, RDATA and PTAR.
- **Error SYNC:** write with 1010 in SYNC.
  - PTAR follows, then `done` with `err=1`.
  - `rdata` keeps its previous value.
- **Reset mid-ADDR:** assert `lpc_reset` during the second ADDR cycle.
  - Next cycle shows all reset values with no `done`.
  - A following request completes normally.
- **Timeout (macro on, `WAIT_LIMIT=4`):** `lpc_ad_in` held at 1111.
  - Four SYNC cycles, then four ABORT cycles with `frame=1`, `ad=1111`.
  - Then `done=1`, `err=1`.
